// File: rtl/axi_refill_master_pkg.sv
// Shared AXI definitions for the cache-line refill master: FSM encoding,
// AXI burst/response codes and the per-beat protocol error rule.
package axi_refill_master_pkg;

  // Refill FSM encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAr   = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  // AXI burst type and response codes
  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [1:0] AxiRespOkay  = 2'b00;

  // A beat is bad if the slave flagged it, or if r_last disagrees with our own beat count.
  function automatic logic beat_error(input logic [1:0] resp,
                                      input logic       last,
                                      input logic       final_beat);
    return (resp != AxiRespOkay) || (last != final_beat);
  endfunction

endpackage

// File: rtl/axi_refill_master.sv
// Cache-line refill master: accepts one line request, issues a single INCR
// read burst for the aligned line, assembles the beats into one wide word
// and hands it to the consumer with a sticky error flag.
module axi_refill_master
  import axi_refill_master_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 256,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned LINE_BYTES     = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [LINE_BYTES*8-1:0]   rsp_data,
  output logic                      rsp_err,
  output logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]                ar_len,
  output logic [2:0]                ar_size,
  output logic [1:0]                ar_burst,
  output logic [AXI_ID_WIDTH-1:0]   ar_id,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  input  logic [AXI_DATA_WIDTH-1:0] r_data,
  input  logic [1:0]                r_resp,
  input  logic                      r_last,
  input  logic                      r_valid,
  output logic                      r_ready
);

  localparam int unsigned BeatBytes = AXI_DATA_WIDTH / 8;
  localparam int unsigned Beats     = LINE_BYTES / BeatBytes;
  localparam int unsigned CntW      = $clog2(Beats) + 1;

  localparam logic [AXI_ADDR_WIDTH-1:0] LineMask = AXI_ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [CntW-1:0]           LastIdx  = CntW'(Beats - 1);

  logic [1:0]                state_q, state_d;
  logic                      ar_valid_q, ar_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [CntW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [LINE_BYTES*8-1:0]   rsp_data_q, rsp_data_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      final_beat;

  assign final_beat = (beat_cnt_q == LastIdx);

  // Burst shape is fixed by the parameters; only the address varies per refill.
  assign ar_len   = 8'(Beats - 1);
  assign ar_size  = 3'($clog2(BeatBytes));
  assign ar_burst = AxiBurstIncr;
  assign ar_id    = '0;
  assign ar_addr  = ar_addr_q;
  assign ar_valid = ar_valid_q;

  // req_ready is gated by rst_n so it reads low for the whole reset pulse.
  assign req_ready = rst_n && (state_q == StIdle);
  assign r_ready   = (state_q == StData);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Next-state and datapath update for the refill sequence
  always_comb begin
    state_d    = state_q;
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    beat_cnt_d = beat_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d    = StAr;
          ar_valid_d = 1'b1;
          ar_addr_d  = req_addr & ~LineMask;
          rsp_err_d  = 1'b0;
        end
      end
      StAr: begin
        if (ar_ready) begin
          state_d    = StData;
          ar_valid_d = 1'b0;
          beat_cnt_d = '0;
        end
      end
      StData: begin
        if (r_valid) begin
          rsp_data_d[32'(beat_cnt_q) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = r_data;
          rsp_err_d  = rsp_err_q | beat_error(r_resp, r_last, final_beat);
          beat_cnt_d = beat_cnt_q + 1'b1;
          // The beat count alone ends the burst; a stray r_last only raises the error.
          if (final_beat) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset; a reset abandons any refill in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      beat_cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      beat_cnt_q <= beat_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule

// File: doc/axi_refill_master.md
AXI_REFILL_MASTER -- requirements
Module: axi_refill_master

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 256, AXI data bus width in bits.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width in bits.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, ID width; ar_id constant 0.
REQ-004 SHALL have parameter LINE_BYTES, default 128, refill line size; BEATS = LINE_BYTES/(AXI_DATA_WIDTH/8), power of 2, 1..256.
REQ-005 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 req_valid  in  1  refill request
 req_ready  out  1  request accepted when high with req_valid
 req_addr  in  AXI_ADDR_WIDTH  any byte address within target line
 rsp_valid  out  1  line available
 rsp_ready  in  1  consumer accepts line
 rsp_data  out  LINE_BYTES*8  assembled line, beat 0 in LSBs
 rsp_err  out  1  refill error, qualified by rsp_valid
 ar_addr  out  AXI_ADDR_WIDTH  line-aligned burst address
 ar_len  out  8  BEATS-1
 ar_size  out  3  log2(AXI_DATA_WIDTH/8)
 ar_burst  out  2  2'b01 (INCR)
 ar_id  out  AXI_ID_WIDTH  all zeros
 ar_valid  out  1  address valid
 ar_ready  in  1  address accepted
 r_data  in  AXI_DATA_WIDTH  read beat
 r_resp  in  2  beat response
 r_last  in  1  final beat marker
 r_valid  in  1  beat valid
 r_ready  out  1  beat accepted

Function
REQ-006 SHALL implement FSM IDLE -> AR -> DATA -> RESP -> IDLE; no other states.
REQ-007 IDLE: req_ready=1, all other outputs inactive; req_valid&req_ready latches req_addr with low log2(LINE_BYTES) bits cleared and moves to AR.
REQ-008 AR: ar_valid=1 from the cycle after acceptance; ar_addr/len/size/burst stable until ar_valid&ar_ready; then DATA next cycle.
REQ-009 ar_valid SHALL NOT drop before ar_ready; a single-cycle ar_ready pulse with ar_valid high completes the handshake.
REQ-010 DATA: r_ready=1; each r_valid&r_ready writes r_data into rsp_data slice beat_cnt and increments beat_cnt (width log2(BEATS)+1, cleared on entry to DATA).
REQ-011 Burst end SHALL be decided by beat count only: the BEATS-th accepted beat moves to RESP next cycle.
REQ-012 rsp_err SHALL be sticky for the refill, set if any beat has r_resp!=2'b00, r_last=1 on a non-final beat, or r_last=0 on the final beat; cleared on request acceptance.
REQ-013 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&rsp_ready; then IDLE, req_ready=1 next cycle.
REQ-014 Beats arriving outside DATA SHALL be ignored (r_ready=0).
REQ-015 Minimum latency: req accept at cycle T, ar_valid at T+1; rsp_valid one cycle after final beat handshake.
REQ-016 Only one outstanding refill; req_ready=0 in AR, DATA and RESP.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE, beat_cnt=0, rsp_data=0, rsp_err=0, rsp_valid=0, ar_valid=0, r_ready=0, ar_addr=0, req_ready=0 while asserted, 1 after release.
REQ-018 Reset mid-burst SHALL abandon the refill with no rsp_valid; remaining beats are not consumed.

Structure
REQ-019 FSM state encoding and AXI burst/resp constants (INCR=2'b01, OKAY=2'b00) SHALL live in the shared AXI package.
REQ-020 Single module; no sub-modules.

Verification
REQ-021 req_addr=0x1234_5678, slave OKAY, no stalls -> ar_addr=0x1234_5600, ar_len=3, ar_size=5, ar_burst=1; rsp_data beats 0..3 in order; rsp_err=0.
REQ-022 ar_ready delayed 5 cycles, r_valid gaps of 2 cycles -> ar_valid held stable; line identical to no-stall case.
REQ-023 Beat 2 with r_resp=2'b10 -> all 4 beats consumed, rsp_err=1.
REQ-024 r_last on beat 1 of 4 -> burst still completes after 4 beats, rsp_err=1; missing r_last on beat 3 -> rsp_err=1.
REQ-025 rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, req_ready=0; rst_n pulsed low during DATA -> IDLE, all outputs at reset values.
